// File: rtl/alu_issue_stage.sv
// Two-stage issue/capture front-end around an external 74181-style ALU for the DLX integer datapath.
// Optional overflow trap is enabled by defining ALU_OVF_TRAP_EN.
`timescale 1ns/1ps
module alu_issue_stage #(
  parameter int N     = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cin,
  input  logic [N-1:0]     alu_out,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             trap,
  input  logic             trap_clr
);

  localparam logic [3:0] OP_ADD = 4'd0, OP_ADDU = 4'd1, OP_SUB = 4'd2, OP_SUBU = 4'd3,
                         OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_PASSB = 4'd7,
                         OP_SEQ = 4'd8, OP_SNE = 4'd9, OP_SLT = 4'd10, OP_SGT = 4'd11,
                         OP_SLE = 4'd12, OP_SGE = 4'd13, OP_SLTU = 4'd14, OP_SGEU = 4'd15;

  logic             vld_p1;
  logic [3:0]       op_p1;
  logic [TAG_W-1:0] tag_p1;
  logic             s2_take;
  logic             accept;
  logic             trap_set;
  logic             ovf_op;
  logic [N-1:0]     res_p1;

  // {s, m, cin}; everything not listed is an a-b subtract (SUB/SUBU and compares)
  function automatic logic [5:0] ctrl_of(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDU: ctrl_of = {4'd9, 1'b1, 1'b0};
      OP_AND:          ctrl_of = {4'd14, 1'b0, 1'b0};
      OP_OR:           ctrl_of = {4'd11, 1'b0, 1'b0};
      OP_XOR:          ctrl_of = {4'd9, 1'b0, 1'b0};
      OP_PASSB:        ctrl_of = {4'd10, 1'b0, 1'b0};
      default:         ctrl_of = {4'd6, 1'b1, 1'b1};
    endcase
  endfunction

  function automatic logic [N-1:0] result_of(input logic [3:0] op, input logic [N-1:0] r,
                                             input logic cout, input logic ovf,
                                             input logic b_nz);
    logic z, lt, ltu, bit0;
    z    = (r == '0);
    lt   = r[N-1] ^ ovf;
    // the ALU reports cout=0 for a b=0 subtract, which is not a borrow
    ltu  = ~cout & b_nz;
    bit0 = 1'b0;
    case (op)
      OP_SEQ:  bit0 = z;
      OP_SNE:  bit0 = ~z;
      OP_SLT:  bit0 = lt;
      OP_SGE:  bit0 = ~lt;
      OP_SGT:  bit0 = ~lt & ~z;
      OP_SLE:  bit0 = lt | z;
      OP_SLTU: bit0 = ltu;
      OP_SGEU: bit0 = ~ltu;
      default: bit0 = 1'b0;
    endcase
    result_of = op[3] ? {{(N-1){1'b0}}, bit0} : r;
  endfunction

  assign ovf_op   = vld_p1 & ((op_p1 == OP_ADD) | (op_p1 == OP_SUB));
  assign res_p1   = result_of(op_p1, alu_out, alu_cout, alu_ovf, alu_b != '0);
  assign s2_take  = vld_p1 & (~out_valid | out_ready);
  assign in_ready = (~vld_p1 | s2_take) & ~trap;
  assign accept   = in_valid & in_ready;

`ifdef ALU_OVF_TRAP_EN
  assign trap_set = s2_take & ovf_op & alu_ovf;

  always_ff @(posedge clk) begin
    if (!reset_n)      trap <= 1'b0;
    else if (trap_set) trap <= 1'b1;
    else if (trap_clr) trap <= 1'b0;
  end
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign trap_set        = 1'b0;
  assign trap            = 1'b0;
`endif

  // Stage 1: operands and ALU control
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      op_p1   <= '0;
      tag_p1  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_s   <= '0;
      alu_m   <= 1'b0;
      alu_cin <= 1'b0;
    end else begin
      if (accept) begin
        op_p1                  <= in_op;
        tag_p1                 <= in_tag;
        alu_a                  <= in_a;
        alu_b                  <= in_b;
        {alu_s, alu_m, alu_cin} <= ctrl_of(in_op);
      end
      if (trap_set)     vld_p1 <= 1'b0;
      else if (accept)  vld_p1 <= 1'b1;
      else if (s2_take) vld_p1 <= 1'b0;
    end
  end

  // Stage 2: captured result toward writeback
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
    end else if (s2_take) begin
      out_valid <= ~trap_set;
      out_data  <= res_p1;
      out_tag   <= tag_p1;
      out_ovf   <= ovf_op & alu_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural model of the external ALU.
`timescale 1ns/1ps
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, out_ovf, trap, trap_clr;
  logic [3:0]  in_op, alu_s;
  logic [31:0] in_a, in_b, alu_a, alu_b, alu_out, out_data;
  logic [4:0]  in_tag, out_tag;
  logic        alu_m, alu_cin, alu_cout, alu_ovf;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        ovf;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.N(32), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_ovf(out_ovf), .trap(trap), .trap_clr(trap_clr)
  );

  // External ALU: only the control combinations the DLX datapath uses
  always_comb begin
    logic [32:0] sum;
    sum      = '0;
    alu_out  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    if (alu_m && alu_s == 4'd9 && !alu_cin) begin
      sum      = {1'b0, alu_a} + {1'b0, alu_b};
      alu_out  = sum[31:0];
      alu_cout = sum[32];
      alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
    end else if (alu_m && alu_s == 4'd6 && alu_cin) begin
      alu_out  = alu_a - alu_b;
      alu_cout = (alu_b != 0) && (alu_a >= alu_b);
      alu_ovf  = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
    end else if (!alu_m) begin
      case (alu_s)
        4'd14:   alu_out = alu_a & alu_b;
        4'd11:   alu_out = alu_a | alu_b;
        4'd9:    alu_out = alu_a ^ alu_b;
        4'd10:   alu_out = alu_b;
        default: alu_out = '0;
      endcase
    end
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops one expectation per writeback handshake
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result_tag", 64'(out_tag), 64'h3F);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("data_tag%0d", e.tag), 64'(out_data), 64'(e.data));
          chk($sformatf("tag_tag%0d", e.tag), 64'(out_tag), 64'(e.tag));
          chk($sformatf("ovf_tag%0d", e.tag), 64'(out_ovf), 64'(e.ovf));
        end
      end
    end
  end

  // Offer one op starting at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] edata, input logic eovf,
                      input bit expect_it, output int waited);
    logic ok;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    if (expect_it) q.push_back('{edata, tag, eovf});
    waited = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) break;
      waited++;
      if (waited > 20) begin
        chk("send_timeout", 64'(waited), 64'd0);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_state(input string pfx);
    chk({pfx, "_out_valid"}, 64'(out_valid), 0);
    chk({pfx, "_in_ready"}, 64'(in_ready), 1);
    chk({pfx, "_alu_a"}, 64'(alu_a), 0);
    chk({pfx, "_alu_b"}, 64'(alu_b), 0);
    chk({pfx, "_alu_ctl"}, 64'({alu_s, alu_m, alu_cin}), 0);
    chk({pfx, "_out_data"}, 64'(out_data), 0);
    chk({pfx, "_out_tag"}, 64'(out_tag), 0);
    chk({pfx, "_out_ovf"}, 64'(out_ovf), 0);
    chk({pfx, "_trap"}, 64'(trap), 0);
  endtask

  initial begin
    int w;
    logic [31:0] hd;
    logic [4:0]  ht;
    reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1; trap_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst0");
    reset_n = 1'b1;
    @(posedge clk); #1;

`ifdef ALU_OVF_TRAP_EN
    send(4'd2, 32'h8000_0000, 32'd1, 5'd30, 0, 0, 1'b0, w);
    repeat (3) @(posedge clk);
    #1;
    chk("trap_set", 64'(trap), 1);
    chk("trap_no_valid", 64'(out_valid), 0);
    chk("trap_in_ready", 64'(in_ready), 0);
    trap_clr = 1'b1;
    @(posedge clk); #1;
    trap_clr = 1'b0;
    chk("trap_cleared", 64'(trap), 0);
    send(4'd0, 32'd1, 32'd1, 5'd31, 32'd2, 1'b0, 1'b1, w);
    wait_drain();
`else
    send(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd1, 32'h8000_0000, 1'b1, 1'b1, w);
    chk("add_alu_ctl", 64'({alu_s, alu_m, alu_cin}), 64'({4'd9, 1'b1, 1'b0}));
    chk("add_alu_a", 64'(alu_a), 64'h7FFF_FFFF);
    chk("add_alu_b", 64'(alu_b), 64'd1);
    wait_drain();
`endif

    send(4'd14, 32'd5, 32'd0, 5'd2, 32'd0, 1'b0, 1'b1, w);
    send(4'd14, 32'd0, 32'd5, 5'd3, 32'd1, 1'b0, 1'b1, w);
    send(4'd15, 32'd0, 32'd0, 5'd4, 32'd1, 1'b0, 1'b1, w);
    send(4'd10, 32'h8000_0000, 32'd1, 5'd5, 32'd1, 1'b0, 1'b1, w);
    send(4'd11, 32'd3, 32'd3, 5'd6, 32'd0, 1'b0, 1'b1, w);
    send(4'd12, 32'd3, 32'd3, 5'd7, 32'd1, 1'b0, 1'b1, w);
    send(4'd8, 32'd7, 32'd7, 5'd8, 32'd1, 1'b0, 1'b1, w);
    send(4'd9, 32'd7, 32'd7, 5'd9, 32'd0, 1'b0, 1'b1, w);
    send(4'd13, 32'd2, 32'd5, 5'd10, 32'd0, 1'b0, 1'b1, w);
    send(4'd10, 32'hFFFF_FFFF, 32'd0, 5'd11, 32'd1, 1'b0, 1'b1, w);
    send(4'd2, 32'd10, 32'd3, 5'd12, 32'd7, 1'b0, 1'b1, w);
    send(4'd1, 32'h7FFF_FFFF, 32'd1, 5'd13, 32'h8000_0000, 1'b0, 1'b1, w);
    send(4'd3, 32'h8000_0000, 32'd1, 5'd14, 32'h7FFF_FFFF, 1'b0, 1'b1, w);
    wait_drain();

    // back-to-back stream: every op must be accepted without a stall cycle
    send(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd15, 32'hF000_F000, 1'b0, 1'b1, w);
    send(4'd5, 32'hF0F0_F0F0, 32'h0F0F_0000, 5'd16, 32'hFFFF_F0F0, 1'b0, 1'b1, w);
    chk("stream_wait_or", 64'(w), 0);
    send(4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 5'd17, 32'h5555_5555, 1'b0, 1'b1, w);
    chk("stream_wait_xor", 64'(w), 0);
    send(4'd7, 32'h0000_1234, 32'hDEAD_BEEF, 5'd18, 32'hDEAD_BEEF, 1'b0, 1'b1, w);
    chk("stream_wait_passb", 64'(w), 0);
    wait_drain();

    // stall writeback, fill both stages, then release
    out_ready = 1'b0;
    send(4'd6, 32'h0000_00FF, 32'h0000_0F0F, 5'd19, 32'h0000_0FF0, 1'b0, 1'b1, w);
    send(4'd0, 32'd100, 32'd23, 5'd20, 32'd123, 1'b0, 1'b1, w);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 0);
    chk("stall_valid", 64'(out_valid), 1);
    hd = out_data; ht = out_tag;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_data_%0d", i), 64'(out_data), 64'(hd));
      chk($sformatf("hold_tag_%0d", i), 64'(out_tag), 64'(ht));
      chk($sformatf("hold_alu_a_%0d", i), 64'(alu_a), 64'd100);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // reset with both stages occupied: in-flight ops are dropped
    out_ready = 1'b0;
    send(4'd5, 32'h1111_0000, 32'h0000_2222, 5'd21, 0, 1'b0, 1'b0, w);
    send(4'd0, 32'd9, 32'd9, 5'd22, 0, 1'b0, 1'b0, w);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("rst1");
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_idle", 64'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1);
  end

endmodule
